// File: rtl/vectorgen_pkg.sv
// Shared definitions for the runtime-configurable vector generator:
// FSM state encoding and kernel-width clamping.
package vectorgen_pkg;

    typedef enum logic [2:0] {
        EMPTY    = 3'd0,
        WAIT_CUR = 3'd1,
        NEED_NXT = 3'd2,
        WAIT_NXT = 3'd3,
        RDY      = 3'd4
    } vg_state_e;

    // A zero width still has one column; anything wider than the array supports is cut back.
    function automatic int clamp_kernel(input int width, input int max_k);
        if (width < 1) begin
            return 1;
        end
        if (width > max_k) begin
            return max_k;
        end
        return width;
    endfunction

endpackage

// File: rtl/vectorgen_lane_sel.sv
// Serial-lane mux: picks element NUM_PE+kw-1 of {NXT, CUR}, or 0 when kw is 0.
// That index always lands in NXT, so only NXT is brought in.
module vectorgen_lane_sel #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PE     = 4,
    parameter int MAX_KERNEL = 5,
    parameter int KW_W       = $clog2(MAX_KERNEL + 1)
) (
    input  logic [NUM_PE*DATA_WIDTH-1:0] nxt,
    input  logic [KW_W-1:0]              kw,
    output logic [DATA_WIDTH-1:0]        lane
);

    always_comb begin
        lane = '0;
        for (int i = 1; i < MAX_KERNEL; i++) begin
            if (kw == KW_W'(i)) begin
                lane = nxt[(i-1)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/vectorgen_kw.sv
// Vector generator with per-row kernel width: double-buffers FIFO words, steps the
// kernel column on SHIFT, and stalls automatically while the FIFO is empty.
module vectorgen_kw
    import vectorgen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PE     = 4,
    parameter int MAX_KERNEL = 5,
    parameter int KW_W       = $clog2(MAX_KERNEL + 1)
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [KW_W-1:0]                  CFG_KERNEL_W,
    input  logic                             VECTORGEN_POP,
    input  logic                             VECTORGEN_SHIFT,
    input  logic                             VECTORGEN_NEXTROW,
    input  logic                             INBUF_EMPTY,
    output logic                             INBUF_POP,
    input  logic [NUM_PE*DATA_WIDTH-1:0]     VECTORGEN_DATA_IN,
    output logic [(NUM_PE+1)*DATA_WIDTH-1:0] VECTORGEN_DATA_OUT,
    output logic                             VECTORGEN_READY,
    output logic [KW_W-1:0]                  VECTORGEN_KW,
    output logic                             VECTORGEN_ERR
);

    localparam int WORD_W = NUM_PE * DATA_WIDTH;

    vg_state_e         state, state_n;
    logic [WORD_W-1:0] cur, nxt;
    logic [KW_W-1:0]   kw, kw_n, k;
    logic              err;
    logic              pop_req, latch_k, ld_cur, ld_nxt, cur_from_nxt, cmd_any;
    logic [DATA_WIDTH-1:0] lane;

    assign cmd_any = VECTORGEN_POP | VECTORGEN_SHIFT | VECTORGEN_NEXTROW;

    always_comb begin
        state_n      = state;
        kw_n         = kw;
        pop_req      = 1'b0;
        latch_k      = 1'b0;
        ld_cur       = 1'b0;
        ld_nxt       = 1'b0;
        cur_from_nxt = 1'b0;
        case (state)
            EMPTY: begin
                if (!INBUF_EMPTY) begin
                    pop_req = 1'b1;
                    latch_k = 1'b1;
                    state_n = WAIT_CUR;
                end
            end
            WAIT_CUR: begin
                ld_cur = 1'b1;
                if (!INBUF_EMPTY) begin
                    pop_req = 1'b1;
                    state_n = WAIT_NXT;
                end else begin
                    state_n = NEED_NXT;
                end
            end
            NEED_NXT: begin
                if (!INBUF_EMPTY) begin
                    pop_req = 1'b1;
                    state_n = WAIT_NXT;
                end
            end
            WAIT_NXT: begin
                ld_nxt  = 1'b1;
                state_n = RDY;
            end
            RDY: begin
                if (VECTORGEN_NEXTROW) begin
                    kw_n    = '0;
                    state_n = EMPTY;
                end else if (VECTORGEN_POP) begin
                    // Refill NXT right away so a POP costs a single bubble cycle.
                    cur_from_nxt = 1'b1;
                    kw_n         = '0;
                    if (!INBUF_EMPTY) begin
                        pop_req = 1'b1;
                        state_n = WAIT_NXT;
                    end else begin
                        state_n = NEED_NXT;
                    end
                end else if (VECTORGEN_SHIFT) begin
                    kw_n = (kw == k - KW_W'(1)) ? '0 : kw + KW_W'(1);
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= EMPTY;
            cur   <= '0;
            nxt   <= '0;
            kw    <= '0;
            k     <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            kw    <= kw_n;
            if (latch_k) begin
                k <= KW_W'(clamp_kernel(int'(CFG_KERNEL_W), MAX_KERNEL));
            end
            if (ld_cur) begin
                cur <= VECTORGEN_DATA_IN;
            end else if (cur_from_nxt) begin
                cur <= nxt;
            end
            if (ld_nxt) begin
                nxt <= VECTORGEN_DATA_IN;
            end
            if (cmd_any && state != RDY) begin
                err <= 1'b1;
            end
        end
    end

    vectorgen_lane_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PE     (NUM_PE),
        .MAX_KERNEL (MAX_KERNEL),
        .KW_W       (KW_W)
    ) u_lane_sel (
        .nxt  (nxt),
        .kw   (kw),
        .lane (lane)
    );

    assign INBUF_POP          = pop_req & ~RESET;
    assign VECTORGEN_READY    = (state == RDY);
    assign VECTORGEN_KW       = kw;
    assign VECTORGEN_ERR      = err;
    assign VECTORGEN_DATA_OUT = {lane, cur};

endmodule

// File: tb/tb_vectorgen_kw.sv
// Scoreboard bench for vectorgen_kw: a FIFO model feeds words, expected outputs are
// queued when each command is driven and compared once the block is ready again.
module tb_vectorgen_kw;

    localparam int DW  = 8;
    localparam int NPE = 4;
    localparam int MK  = 5;
    localparam int KWW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [KWW-1:0]   cfg_kernel_w;
    logic             vg_pop, vg_shift, vg_nextrow;
    logic             inbuf_empty;
    logic             inbuf_pop;
    logic [31:0]      data_in = '0;
    logic [39:0]      data_out;
    logic             ready;
    logic [KWW-1:0]   kw_out;
    logic             err_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] fifo_mem [0:63];
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    logic [31:0] m_cur, m_nxt;
    int          m_kw, m_k;
    logic [39:0] sb [$];

    vectorgen_kw #(
        .DATA_WIDTH (DW),
        .NUM_PE     (NPE),
        .MAX_KERNEL (MK),
        .KW_W       (KWW)
    ) dut (
        .CLK                (clk),
        .RESET              (rst),
        .CFG_KERNEL_W       (cfg_kernel_w),
        .VECTORGEN_POP      (vg_pop),
        .VECTORGEN_SHIFT    (vg_shift),
        .VECTORGEN_NEXTROW  (vg_nextrow),
        .INBUF_EMPTY        (inbuf_empty),
        .INBUF_POP          (inbuf_pop),
        .VECTORGEN_DATA_IN  (data_in),
        .VECTORGEN_DATA_OUT (data_out),
        .VECTORGEN_READY    (ready),
        .VECTORGEN_KW       (kw_out),
        .VECTORGEN_ERR      (err_out)
    );

    always #5 clk = ~clk;

    // One-cycle-latency FIFO
    assign inbuf_empty = (wr_cnt == rd_cnt);
    always @(posedge clk) begin
        if (inbuf_pop && wr_cnt != rd_cnt) begin
            data_in <= fifo_mem[rd_cnt % 64];
            rd_cnt  <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] model_out(input logic [31:0] c, input logic [31:0] n, input int kw);
        logic [63:0] cat;
        logic [7:0]  lane;
        cat  = {n, c};
        lane = (kw == 0) ? 8'h00 : cat[(NPE+kw-1)*DW +: DW];
        return {lane, c};
    endfunction

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_cnt % 64] = w;
        wr_cnt++;
    endtask

    task automatic expect_fill(input logic [31:0] w0, input logic [31:0] w1, input int cfg);
        m_cur = w0;
        m_nxt = w1;
        m_kw  = 0;
        m_k   = (cfg == 0) ? 1 : (cfg > MK) ? MK : cfg;
        sb.push_back(model_out(m_cur, m_nxt, m_kw));
    endtask

    task automatic drive_cmd(input logic p, input logic s, input logic n);
        vg_pop     = p;
        vg_shift   = s;
        vg_nextrow = n;
        @(negedge clk);
        vg_pop     = 1'b0;
        vg_shift   = 1'b0;
        vg_nextrow = 1'b0;
    endtask

    task automatic expect_ready(input string tag, input int lat);
        int n;
        logic [39:0] exp;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        chk({tag, "_out"}, 64'(data_out), 64'(exp));
    endtask

    task automatic do_shift(input string tag);
        m_kw = (m_kw == m_k - 1) ? 0 : m_kw + 1;
        sb.push_back(model_out(m_cur, m_nxt, m_kw));
        drive_cmd(1'b0, 1'b1, 1'b0);
        expect_ready(tag, 0);
        chk({tag, "_kw"}, 64'(kw_out), 64'(m_kw));
    endtask

    task automatic do_pop(input string tag, input logic [31:0] next_w, input logic with_shift);
        m_cur = m_nxt;
        m_nxt = next_w;
        m_kw  = 0;
        sb.push_back(model_out(m_cur, m_nxt, m_kw));
        drive_cmd(1'b1, with_shift, 1'b0);
        chk({tag, "_bubble"}, 64'(ready), 64'h0);
        chk({tag, "_cur"}, 64'(data_out[31:0]), 64'(m_cur));
        expect_ready(tag, 1);
        chk({tag, "_kw"}, 64'(kw_out), 64'h0);
    endtask

    task automatic nextrow_fill(input string tag, input logic [31:0] w0, input logic [31:0] w1, input int cfg);
        cfg_kernel_w = KWW'(cfg);
        push_word(w0);
        push_word(w1);
        expect_fill(w0, w1, cfg);
        drive_cmd(1'b0, 1'b0, 1'b1);
        expect_ready(tag, 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        cfg_kernel_w = 3'd3;
        vg_pop       = 1'b0;
        vg_shift     = 1'b0;
        vg_nextrow   = 1'b0;
        push_word(32'h04030201);
        push_word(32'h08070605);
        repeat (2) @(negedge clk);
        chk("rst_out", 64'(data_out), 64'h0);
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_kw", 64'(kw_out), 64'h0);
        chk("rst_err", 64'(err_out), 64'h0);
        chk("rst_pop", 64'(inbuf_pop), 64'h0);

        // Fill from reset, K=3
        expect_fill(32'h04030201, 32'h08070605, 3);
        rst = 1'b0;
        #1;
        chk("fill_pop_c0", 64'(inbuf_pop), 64'h1);
        @(negedge clk);
        chk("fill_pop_c1", 64'(inbuf_pop), 64'h1);
        @(negedge clk);
        chk("fill_pop_c2", 64'(inbuf_pop), 64'h0);
        chk("fill_ready_c2", 64'(ready), 64'h0);
        expect_ready("fill", 1);
        chk("fill_lit", 64'(data_out), 64'h0004030201);
        do_shift("sh1");
        chk("sh1_lit", 64'(data_out), 64'h0504030201);
        do_shift("sh2");
        chk("sh2_lit", 64'(data_out), 64'h0604030201);
        do_shift("sh3");
        chk("sh3_lit", 64'(data_out), 64'h0004030201);

        push_word(32'h0C0B0A09);
        do_pop("pop", 32'h0C0B0A09, 1'b0);
        chk("pop_lit", 64'(data_out), 64'h0008070605);
        do_shift("pop_sh");
        chk("pop_sh_lit", 64'(data_out), 64'h0908070605);
        chk("err_clean", 64'(err_out), 64'h0);

        // K=5: lane walks through all of NXT, then wraps
        nextrow_fill("k5_fill", 32'h04030201, 32'h08070605, 5);
        for (int i = 0; i < 4; i++) begin
            do_shift("k5_sh");
        end
        chk("k5_last_lane", 64'(data_out[39:32]), 64'h08);
        do_shift("k5_wrap");
        chk("k5_wrap_lane", 64'(data_out[39:32]), 64'h00);

        // Clamp 7 -> 5
        nextrow_fill("k7_fill", 32'h14131211, 32'h18171615, 7);
        for (int i = 0; i < 5; i++) begin
            do_shift("k7_sh");
        end

        // Zero behaves as one
        nextrow_fill("k0_fill", 32'h24232221, 32'h28272625, 0);
        do_shift("k0_sh1");
        do_shift("k0_sh2");

        // FIFO runs dry after the first word
        cfg_kernel_w = 3'd3;
        push_word(32'h34333231);
        drive_cmd(1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("stall_ready", 64'(ready), 64'h0);
        chk("stall_pop", 64'(inbuf_pop), 64'h0);
        expect_fill(32'h34333231, 32'h38373635, 3);
        push_word(32'h38373635);
        #1;
        chk("resume_pop", 64'(inbuf_pop), 64'h1);
        expect_ready("resume", 2);

        // Command while not ready, POP+SHIFT priority, refetch
        push_word(32'h44434241);
        push_word(32'h48474645);
        expect_fill(32'h44434241, 32'h48474645, 3);
        drive_cmd(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("err_wait_nxt_ready", 64'(ready), 64'h0);
        drive_cmd(1'b0, 1'b1, 1'b0);
        chk("err_set", 64'(err_out), 64'h1);
        expect_ready("err_fill", 0);
        chk("err_kw_ignored", 64'(kw_out), 64'h0);
        do_shift("err_sh");
        push_word(32'h4C4B4A49);
        do_pop("popsh", 32'h4C4B4A49, 1'b1);
        nextrow_fill("refetch", 32'h54535251, 32'h58575655, 3);
        chk("err_sticky", 64'(err_out), 64'h1);

        // Reset during WAIT_NXT
        push_word(32'h64636261);
        push_word(32'h68676665);
        drive_cmd(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_out", 64'(data_out), 64'h0);
        chk("mid_rst_ready", 64'(ready), 64'h0);
        chk("mid_rst_err", 64'(err_out), 64'h0);
        chk("mid_rst_pop", 64'(inbuf_pop), 64'h0);
        push_word(32'h74737271);
        push_word(32'h78777675);
        @(negedge clk);
        chk("mid_rst_pop_hold", 64'(inbuf_pop), 64'h0);
        expect_fill(32'h74737271, 32'h78777675, 3);
        rst = 1'b0;
        expect_ready("refill", 3);
        do_shift("refill_sh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vectorgen_kw.md
# vectorgen_kw

Runtime-configurable successor to `vectorgen`. It sits between the PU input FIFO and the PE array, and is driven by `PU_controller`. It holds the current `NUM_PE`-element word and a prefetched next word. Every cycle it presents the current word to the PEs, plus one serial lane carrying element `NUM_PE+kw-1` of the two-word concatenation, where `kw` is the kernel column. Unlike the fixed-kernel block, it adds:
- a kernel width set per row segment (1..`MAX_KERNEL`);
- automatic prefetch and stall on FIFO empty;
- a sticky protocol-error flag.

## Interface
Parameters:
- `DATA_WIDTH`, 8, bits per element
- `NUM_PE`, 4, elements per input word / PE count
- `MAX_KERNEL`, 5, largest kernel width; must satisfy 1 ≤ `MAX_KERNEL` ≤ `NUM_PE`+1
- `KW_W`, `$clog2(MAX_KERNEL+1)`, width of kernel-width and kernel-column fields

Ports:
- `CLK` in 1: the single clock
- `RESET` in 1: asynchronous, active-high reset
- `CFG_KERNEL_W` in `KW_W`: kernel width. 0 is treated as 1; values above `MAX_KERNEL` are clamped to `MAX_KERNEL`.
- `VECTORGEN_POP` in 1: advance to the next word
- `VECTORGEN_SHIFT` in 1: advance the kernel column
- `VECTORGEN_NEXTROW` in 1: discard both words and refetch
- `INBUF_EMPTY` in 1: FIFO empty
- `INBUF_POP` out 1: FIFO read request (combinational from state)
- `VECTORGEN_DATA_IN` in `NUM_PE*DATA_WIDTH`: FIFO data, valid the cycle after `INBUF_POP`
- `VECTORGEN_DATA_OUT` out `(NUM_PE+1)*DATA_WIDTH`: `{serial lane, CUR}`
- `VECTORGEN_READY` out 1: output valid; commands are accepted
- `VECTORGEN_KW` out `KW_W`: current kernel column
- `VECTORGEN_ERR` out 1: sticky; set when a command arrives while not ready

## Operation
- Registers:
  - `CUR` and `NXT`, each `NUM_PE` lanes
  - `kw`, the kernel column
  - `K`, the latched kernel width
  - 3-bit state
- States:
  - `EMPTY`: if `!INBUF_EMPTY`, assert `INBUF_POP`, latch `K` from `CFG_KERNEL_W`, go to `WAIT_CUR`.
  - `WAIT_CUR`: `CUR <= DATA_IN`. If `!INBUF_EMPTY`, pop and go to `WAIT_NXT`; else go to `NEED_NXT`.
  - `NEED_NXT`: wait for `!INBUF_EMPTY`, then pop and go to `WAIT_NXT`.
  - `WAIT_NXT`: `NXT <= DATA_IN`; go to `RDY`.
  - `RDY`: `VECTORGEN_READY` is 1. Commands are handled in priority order:
    1. `NEXTROW`: go to `EMPTY`, `kw <= 0`.
    2. `POP`: `CUR <= NXT`, `kw <= 0`. Pop the FIFO in the same cycle if it is not empty, then go to `WAIT_NXT`; otherwise go to `NEED_NXT`.
    3. `SHIFT`: `kw <= (kw == K-1) ? 0 : kw+1`. This wrap starts the next kernel row on the same data.
- Serial lane:
  - `kw == 0` → 0.
  - Otherwise → element `NUM_PE+kw-1` of `{NXT, CUR}`, with element 0 = `CUR` lane 0.
- The index stays at or below `2*NUM_PE-1` by the `MAX_KERNEL` bound.
- When `K == 1`, `SHIFT` keeps `kw` at 0.
- Any of `POP`, `SHIFT` or `NEXTROW` while not in `RDY`:
  - the command is ignored;
  - `VECTORGEN_ERR` is set and held until `RESET`.
- `CFG_KERNEL_W` is sampled only on the `EMPTY` → `WAIT_CUR` transition.

## Timing
- Reset values:
  - state `EMPTY`;
  - `CUR`, `NXT`, `kw`, `K` all 0;
  - `VECTORGEN_DATA_OUT` = 0, `READY` = 0, `KW` = 0, `ERR` = 0;
  - `INBUF_POP` forced to 0 while `RESET` is high.
- Reset asserted mid-operation aborts immediately. Words already popped are lost; the controller restarts the row.
- FIFO read latency is 1 cycle.
- Fill from reset with a non-empty FIFO:
  - pops in cycles 0 and 1;
  - `READY` high from cycle 3.
- `POP` in `RDY` with a non-empty FIFO: `READY` is low for exactly 1 cycle, and the new `CUR` is visible 1 cycle after `POP`.
- `SHIFT`: `kw` and the serial lane update on the next edge. One `SHIFT` per cycle is supported with no bubble.
- `NEXTROW` costs 3 cycles minimum before `READY` returns.
- FIFO empty in `NEED_NXT` or `EMPTY`: the block stalls indefinitely with no pop.
- All outputs except `INBUF_POP` are registered.

## Structure
- `vectorgen_pkg`:
  - state encoding (`EMPTY`, `WAIT_CUR`, `NEED_NXT`, `WAIT_NXT`, `RDY`);
  - kernel-width clamp function.
- Sub-module `vectorgen_lane_sel`: combinational mux from `{NXT, CUR}` and `kw` to the serial element. It is parametrised by `DATA_WIDTH`, `NUM_PE` and `MAX_KERNEL`.

## Test plan
- Reset, then FIFO words `0x04030201`, `0x08070605`; `K=3`:
  - `READY` at cycle 3;
  - out = `0x0004030201`; after `SHIFT` = `0x0504030201`; after a second `SHIFT` = `0x0604030201`; a third `SHIFT` wraps to `0x0004030201`.
- `POP` with the next word `0x0C0B0A09` queued: `READY` drops for 1 cycle, then out = `0x0008070605`; a following `SHIFT` gives `0x0908070605`.
- `K=5`, `NUM_PE=4`: after four `SHIFT`s the serial lane is `0x08` (last NXT element), and the fifth `SHIFT` wraps to 0. Also: `CFG_KERNEL_W=7` clamps to 5, and 0 behaves as 1.
- FIFO empty after the first word: the block stays in `NEED_NXT` with `READY=0`. Pushing a word resumes the fill, with `READY` 2 cycles after the push is visible.
- `SHIFT` during `WAIT_NXT`: ignored, `ERR=1` and sticky. `POP` and `SHIFT` in the same cycle: `POP` wins and `kw=0`. `NEXTROW` then refetches two fresh words.
- Assert `RESET` during `WAIT_NXT`: outputs are 0 immediately and `INBUF_POP` is 0. After release the block refills normally.
